// File: rtl/piso_pkg.sv
// Shared constants and helpers for the PISO serializer.
// State encoding, default word width and counter sizing.
package piso_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef logic [1:0] state_t;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    // The counter also times gaps of up to 15 cycles.
    function automatic int cnt_w(input int w);
        return ($clog2(w) > 4) ? $clog2(w) : 4;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the PISO serializer.
// master drives words in, slave is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = piso_pkg::WIDTH_DEF
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             ser_en;
    logic             busy;
    logic             done;

    modport master (
        output data_in, load_valid,
        input  load_ready, serial_out, ser_en, busy, done
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, serial_out, ser_en, busy, done
    );
endinterface

// File: rtl/piso_bit_counter.sv
// Wrapping counter with clear; terminal count at i_last.
// Times both the bits of a word and the inter-word gap.
module piso_bit_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [CW-1:0] i_last,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc
);
    logic [CW-1:0] r_cnt;

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_last);

    always_ff @(posedge clk) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with a one-word holding buffer.
// Words stream back to back unless an idle gap is configured.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter bit LSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    piso_serializer_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] SH_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] DN_CNT  = CW'(WIDTH - 2);
    localparam logic [CW-1:0] GP_LAST =
        (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_nx;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] w_word;
    logic             r_hold_full;
    logic             w_hold_full_nx;
    logic             r_serial;
    logic             r_ser_en;
    logic             r_busy;
    logic             r_done;
    logic             w_acc;
    logic             w_tc;
    logic             w_last;
    logic             w_gap_end;
    logic             w_pend;
    logic             w_start;
    logic             w_clr;
    logic [CW-1:0]    w_cnt;
    logic [CW-1:0]    w_cnt_last;

    // Shift register always moves toward bit 0, so MSB-first words
    // are bit-reversed on load.
    function automatic logic [WIDTH-1:0] orient(
        input logic [WIDTH-1:0] w
    );
        logic [WIDTH-1:0] o;
        for (int i = 0; i < WIDTH; i++)
            o[i] = LSB_FIRST ? w[i] : w[WIDTH-1-i];
        return o;
    endfunction

    assign bus.load_ready = rst & ~r_hold_full;
    assign bus.serial_out = r_serial;
    assign bus.ser_en     = r_ser_en;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    assign w_acc     = bus.load_valid & bus.load_ready;
    assign w_last    = (r_state == ST_SHIFT) & w_tc;
    assign w_gap_end = (r_state == ST_GAP) & w_tc;
    assign w_pend    = r_hold_full | w_acc;
    assign w_start   = ((r_state == ST_IDLE) & w_acc)
                     | (w_last & ~HAS_GAP & w_pend)
                     | (w_gap_end & w_pend);
    assign w_word     = r_hold_full ? r_hold : bus.data_in;
    assign w_cnt_last = (r_state == ST_GAP) ? GP_LAST : SH_LAST;
    assign w_clr      = w_start | (w_state_nx == ST_IDLE);

    always_comb begin
        w_state_nx     = r_state;
        w_sr_nx        = r_sr;
        w_hold_full_nx = r_hold_full;
        if (w_start) begin
            w_state_nx     = ST_SHIFT;
            w_sr_nx        = orient(w_word);
            w_hold_full_nx = 1'b0;
        end else begin
            if (w_acc)
                w_hold_full_nx = 1'b1;
            unique case (1'b1)
                (r_state == ST_SHIFT) & ~w_tc:
                    w_sr_nx = r_sr >> 1;
                w_last:
                    w_state_nx = HAS_GAP ? ST_GAP : ST_IDLE;
                w_gap_end:
                    w_state_nx = ST_IDLE;
                default: ;
            endcase
        end
    end

    piso_bit_counter #(.CW(CW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_en   (1'b1),
        .i_last (w_cnt_last),
        .o_cnt  (w_cnt),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_sr        <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_serial    <= 1'b0;
            r_ser_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_sr        <= w_sr_nx;
            r_hold_full <= w_hold_full_nx;
            if (w_acc & ~w_start)
                r_hold <= bus.data_in;
            r_ser_en <= (w_state_nx == ST_SHIFT);
            r_serial <= (w_state_nx == ST_SHIFT) & w_sr_nx[0];
            // Bit WIDTH-2 now means the last bit shows next cycle.
            r_done   <= (r_state == ST_SHIFT) & (w_cnt == DN_CNT);
            r_busy   <= (w_state_nx != ST_IDLE) | w_hold_full_nx;
        end
    end
endmodule
